synth_voice_controller: RTL and testbench

- Polyphonic successor to the two-channel PLAY/DEMO button mux in the synth top level.
- Maps NUM_KEYS debounced keys onto NUM_CHANNELS mixer voices, allocating a free voice or stealing the least-recently-allocated one.
- Latches pitch and waveform per voice at note-on.
- Arbitrates between live play and the demo decoder's channel bus, which it forwards to channel_mixer.

---
 rtl/synth_pkg.sv | 15 +
 rtl/voice_picker.sv | 30 +++
 rtl/synth_voice_controller.sv | 149 ++++++++++++++
 tb/tb_synth_voice_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// synth_pkg: shared mode type, default widths and voice record for the synth voice controller
package synth_pkg;
    typedef enum logic {PLAY = 1'b0, DEMO = 1'b1} synth_mode_t;
    localparam int DEF_PITCH_W = 12;
    localparam int DEF_WAVE_W = 2;
    localparam int KEY_IDX_W = 8;
    localparam int RANK_MAX_W = 8;
    typedef struct packed {
        logic [KEY_IDX_W-1:0]   key;
        logic [DEF_PITCH_W-1:0] pitch;
        logic [DEF_WAVE_W-1:0]  wave;
        logic                   active;
        logic [RANK_MAX_W-1:0]  rank;
    } voice_t;
endpackage

// File: rtl/voice_picker.sv
// voice_picker: lowest free voice and oldest (highest-rank) active voice, ties to lowest index
module voice_picker #(
    parameter int NUM_CHANNELS = 4,
    parameter int RANK_W = 2,
    parameter int IDX_W = 2
) (
    input  logic [NUM_CHANNELS-1:0]        active_i,
    input  logic [NUM_CHANNELS*RANK_W-1:0] rank_i,
    output logic [IDX_W-1:0]               free_idx_o,
    output logic                           any_free_o,
    output logic [IDX_W-1:0]               oldest_idx_o
);
    logic [RANK_W-1:0] best;
    logic              found;
    always_comb begin
        free_idx_o = '0;
        any_free_o = ~&active_i;
        oldest_idx_o = '0;
        best = '0;
        found = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--)
            if (!active_i[i]) free_idx_o = IDX_W'(i);
        for (int i = 0; i < NUM_CHANNELS; i++)
            if (active_i[i] && (!found || rank_i[i*RANK_W +: RANK_W] > best)) begin
                found = 1'b1;
                best = rank_i[i*RANK_W +: RANK_W];
                oldest_idx_o = IDX_W'(i);
            end
    end
endmodule

// File: rtl/synth_voice_controller.sv
// synth_voice_controller: polyphonic key-to-voice allocator with PLAY/DEMO output mux
module synth_voice_controller
    import synth_pkg::*;
#(
    parameter int NUM_KEYS = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int PITCH_W = DEF_PITCH_W,
    parameter int WAVE_W = DEF_WAVE_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_KEYS-1:0]                keys_i,
    input  logic [NUM_KEYS*PITCH_W-1:0]        key_pitches_i,
    input  logic [WAVE_W-1:0]                  waveform_sel_i,
    input  logic                               demo_req_i,
    input  logic                               play_req_i,
    input  logic [NUM_CHANNELS-1:0]            demo_channel_ena_i,
    input  logic [NUM_CHANNELS*WAVE_W-1:0]     demo_waveforms_i,
    input  logic [NUM_CHANNELS*PITCH_W-1:0]    demo_pitches_i,
    output logic [NUM_CHANNELS-1:0]            channel_ena_o,
    output logic [NUM_CHANNELS*WAVE_W-1:0]     waveforms_o,
    output logic [NUM_CHANNELS*PITCH_W-1:0]    pitches_o,
    output logic                               demo_ena_o,
    output logic [$clog2(NUM_CHANNELS+1)-1:0]  active_count_o,
    output logic                               steal_o
);
    localparam int KW = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1;
    localparam int IW = $clog2(NUM_CHANNELS);
    localparam int RW = IW;
    localparam int CW = $clog2(NUM_CHANNELS + 1);
    synth_mode_t                    mode_q, mode_d;
    logic [NUM_KEYS-1:0]            keys_q, pend_on_q, pend_on_d, pend_off_q, pend_off_d;
    logic [NUM_KEYS-1:0]            rise, fall, cancel, on_ev, off_ev;
    logic [NUM_CHANNELS-1:0]        act_q, act_d;
    logic [NUM_CHANNELS*KW-1:0]     vkey_q, vkey_d;
    logic [NUM_CHANNELS*PITCH_W-1:0] vpitch_q, vpitch_d;
    logic [NUM_CHANNELS*WAVE_W-1:0] vwave_q, vwave_d;
    logic [NUM_CHANNELS*RW-1:0]     rank_q, rank_d;
    logic [KW-1:0]                  on_k, off_k;
    logic [IW-1:0]                  free_idx, old_idx, hit_v, tgt;
    logic                           any_free, hit, steal_d;
    logic [CW-1:0]                  cnt_d;
    voice_picker #(.NUM_CHANNELS(NUM_CHANNELS), .RANK_W(RW), .IDX_W(IW)) u_picker (
        .active_i     (act_q),
        .rank_i       (rank_q),
        .free_idx_o   (free_idx),
        .any_free_o   (any_free),
        .oldest_idx_o (old_idx)
    );
    always_comb begin
        mode_d = demo_req_i ? DEMO : play_req_i ? PLAY : mode_q;
        rise = keys_i & ~keys_q;
        fall = ~keys_i & keys_q;
        cancel = fall & pend_on_q;
        on_ev = (pend_on_q | rise) & ~cancel;
        off_ev = (pend_off_q | fall) & ~cancel;
        on_k = '0;
        off_k = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (on_ev[i]) on_k = KW'(i);
            if (off_ev[i]) off_k = KW'(i);
        end
        hit = 1'b0;
        hit_v = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--)
            if (act_q[i] && vkey_q[i*KW +: KW] == off_k) begin
                hit = 1'b1;
                hit_v = IW'(i);
            end
        tgt = any_free ? free_idx : old_idx;
        pend_on_d = on_ev;
        pend_off_d = off_ev;
        act_d = act_q;
        vkey_d = vkey_q;
        vpitch_d = vpitch_q;
        vwave_d = vwave_q;
        rank_d = rank_q;
        steal_d = 1'b0;
        if (demo_req_i || play_req_i) begin
            pend_on_d = '0;
            pend_off_d = '0;
            act_d = '0;
            vkey_d = '0;
            vpitch_d = '0;
            vwave_d = '0;
            rank_d = '0;
        end else if (mode_q == DEMO) begin
            pend_on_d = '0;
            pend_off_d = '0;
        end else if (|off_ev) begin
            pend_off_d[off_k] = 1'b0;
            if (hit) begin
                act_d[hit_v] = 1'b0;
                for (int i = 0; i < NUM_CHANNELS; i++)
                    if (act_q[i] && rank_q[i*RW +: RW] > rank_q[hit_v*RW +: RW])
                        rank_d[i*RW +: RW] = rank_q[i*RW +: RW] - 1'b1;
            end
        end else if (|on_ev) begin
            pend_on_d[on_k] = 1'b0;
            steal_d = ~any_free;
            // every other voice ages by one; on a steal the victim is the oldest, so that is all of them
            for (int i = 0; i < NUM_CHANNELS; i++)
                if (act_q[i] && IW'(i) != tgt && (any_free || rank_q[i*RW +: RW] < rank_q[tgt*RW +: RW]))
                    rank_d[i*RW +: RW] = rank_q[i*RW +: RW] + 1'b1;
            act_d[tgt] = 1'b1;
            vkey_d[tgt*KW +: KW] = on_k;
            vpitch_d[tgt*PITCH_W +: PITCH_W] = key_pitches_i[on_k*PITCH_W +: PITCH_W];
            vwave_d[tgt*WAVE_W +: WAVE_W] = waveform_sel_i;
            rank_d[tgt*RW +: RW] = '0;
        end
        cnt_d = '0;
        for (int i = 0; i < NUM_CHANNELS; i++)
            cnt_d = cnt_d + CW'(act_d[i]);
    end
    always_ff @(posedge clk) begin
        keys_q <= keys_i;
        if (rst) begin
            mode_q <= PLAY;
            pend_on_q <= '0;
            pend_off_q <= '0;
            act_q <= '0;
            vkey_q <= '0;
            vpitch_q <= '0;
            vwave_q <= '0;
            rank_q <= '0;
            channel_ena_o <= '0;
            waveforms_o <= '0;
            pitches_o <= '0;
            demo_ena_o <= 1'b0;
            active_count_o <= '0;
            steal_o <= 1'b0;
        end else begin
            mode_q <= mode_d;
            pend_on_q <= pend_on_d;
            pend_off_q <= pend_off_d;
            act_q <= act_d;
            vkey_q <= vkey_d;
            vpitch_q <= vpitch_d;
            vwave_q <= vwave_d;
            rank_q <= rank_d;
            channel_ena_o <= (mode_d == DEMO) ? demo_channel_ena_i : act_d;
            waveforms_o <= (mode_d == DEMO) ? demo_waveforms_i : vwave_d;
            pitches_o <= (mode_d == DEMO) ? demo_pitches_i : vpitch_d;
            demo_ena_o <= mode_d == DEMO;
            active_count_o <= (mode_d == DEMO) ? '0 : cnt_d;
            steal_o <= steal_d;
        end
    end
endmodule

// File: tb/tb_synth_voice_controller.sv
// tb_synth_voice_controller: directed and randomized checks against an age-queue voice model
module tb_synth_voice_controller;
    logic        clk, rst;
    logic [3:0]  keys;
    logic [47:0] key_pitches;
    logic [1:0]  waveform_sel;
    logic        demo_req, play_req;
    logic [1:0]  demo_channel_ena;
    logic [3:0]  demo_waveforms;
    logic [23:0] demo_pitches;
    logic [1:0]  channel_ena;
    logic [3:0]  waveforms;
    logic [23:0] pitches;
    logic        demo_ena;
    logic [1:0]  active_count;
    logic        steal;
    int n_vec = 0;
    int n_err = 0;
    synth_voice_controller #(.NUM_KEYS(4), .NUM_CHANNELS(2), .PITCH_W(12), .WAVE_W(2)) dut (
        .clk(clk), .rst(rst), .keys_i(keys), .key_pitches_i(key_pitches),
        .waveform_sel_i(waveform_sel), .demo_req_i(demo_req), .play_req_i(play_req),
        .demo_channel_ena_i(demo_channel_ena), .demo_waveforms_i(demo_waveforms),
        .demo_pitches_i(demo_pitches), .channel_ena_o(channel_ena), .waveforms_o(waveforms),
        .pitches_o(pitches), .demo_ena_o(demo_ena), .active_count_o(active_count), .steal_o(steal)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // model: voices plus an allocation-order queue (front = oldest)
    int         q[$];
    bit         m_demo;
    bit [3:0]   m_kq, m_pon, m_poff;
    bit [1:0]   m_act;
    int         m_key[2];
    bit [11:0]  m_pit[2];
    bit [1:0]   m_wav[2];
    logic [1:0] e_ena, e_cnt, e_wav0, e_wav1;
    logic [23:0] e_pit;
    logic [3:0] e_wav;
    logic       e_demo, e_steal;
    task automatic model_clear();
        m_pon = 0;
        m_poff = 0;
        m_act = 0;
        q.delete();
        for (int v = 0; v < 2; v++) begin
            m_key[v] = 0;
            m_pit[v] = 0;
            m_wav[v] = 0;
        end
    endtask
    task automatic model_step();
        int k;
        int v;
        bit [11:0] kp;
        e_steal = 0;
        if (demo_req || play_req) begin
            m_demo = demo_req;
            model_clear();
        end else if (!m_demo) begin
            for (int i = 0; i < 4; i++) begin
                if (!keys[i] && m_kq[i]) begin
                    if (m_pon[i]) begin m_pon[i] = 0; m_poff[i] = 0; end
                    else m_poff[i] = 1;
                end
                if (keys[i] && !m_kq[i]) m_pon[i] = 1;
            end
            k = -1;
            for (int i = 3; i >= 0; i--) if (m_poff[i]) k = i;
            if (k >= 0) begin
                m_poff[k] = 0;
                for (int w = 0; w < 2; w++)
                    if (m_act[w] && m_key[w] == k) begin
                        m_act[w] = 0;
                        for (int j = 0; j < q.size(); j++)
                            if (q[j] == w) begin q.delete(j); break; end
                    end
            end else begin
                for (int i = 3; i >= 0; i--) if (m_pon[i]) k = i;
                if (k >= 0) begin
                    m_pon[k] = 0;
                    v = -1;
                    for (int w = 1; w >= 0; w--) if (!m_act[w]) v = w;
                    if (v < 0) begin v = q.pop_front(); e_steal = 1; end
                    kp = key_pitches[k*12 +: 12];
                    m_act[v] = 1;
                    m_key[v] = k;
                    m_pit[v] = kp;
                    m_wav[v] = waveform_sel;
                    q.push_back(v);
                end
            end
        end
        m_kq = keys;
        e_demo = m_demo;
        e_ena = m_demo ? demo_channel_ena : m_act;
        e_pit = m_demo ? demo_pitches : {m_pit[1], m_pit[0]};
        e_wav = m_demo ? demo_waveforms : {m_wav[1], m_wav[0]};
        e_cnt = m_demo ? 2'd0 : 2'(q.size());
    endtask
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        demo_req = 0;
        play_req = 0;
    endtask
    task automatic test_reset();
        rst = 1;
        keys = 0;
        key_pitches = {12'd53, 12'd106, 12'd212, 12'd424};
        waveform_sel = 0;
        demo_req = 0;
        play_req = 0;
        demo_channel_ena = 0;
        demo_waveforms = 0;
        demo_pitches = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        m_demo = 0;
        m_kq = keys;
        model_clear();
        n_vec++; if (channel_ena !== 2'b00) begin n_err++; $display("FAIL reset_ena got %b want 00", channel_ena); end
        n_vec++; if (pitches !== 24'd0) begin n_err++; $display("FAIL reset_pitches got %0h want 0", pitches); end
        n_vec++; if (demo_ena !== 1'b0) begin n_err++; $display("FAIL reset_demo_ena got %b want 0", demo_ena); end
        n_vec++; if (active_count !== 2'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", active_count); end
        n_vec++; if (steal !== 1'b0) begin n_err++; $display("FAIL reset_steal got %b want 0", steal); end
    endtask
    task automatic test_alloc();
        waveform_sel = 2;
        keys = 4'b0010;
        tick();
        n_vec++; if (channel_ena !== 2'b01) begin n_err++; $display("FAIL alloc_ena got %b want 01", channel_ena); end
        n_vec++; if (pitches[11:0] !== 12'd212) begin n_err++; $display("FAIL alloc_pitch got %0d want 212", pitches[11:0]); end
        n_vec++; if (waveforms[1:0] !== 2'd2) begin n_err++; $display("FAIL alloc_wave got %0d want 2", waveforms[1:0]); end
        n_vec++; if (active_count !== 2'd1) begin n_err++; $display("FAIL alloc_count got %0d want 1", active_count); end
    endtask
    task automatic test_steal();
        keys = 4'b0111;
        tick();
        n_vec++; if (channel_ena !== 2'b11) begin n_err++; $display("FAIL steal1_ena got %b want 11", channel_ena); end
        n_vec++; if (pitches[23:12] !== 12'd424) begin n_err++; $display("FAIL steal1_pitch got %0d want 424", pitches[23:12]); end
        n_vec++; if (steal !== 1'b0) begin n_err++; $display("FAIL steal1_pulse got %b want 0", steal); end
        tick();
        n_vec++; if (pitches[11:0] !== 12'd106) begin n_err++; $display("FAIL steal2_pitch got %0d want 106", pitches[11:0]); end
        n_vec++; if (steal !== 1'b1) begin n_err++; $display("FAIL steal2_pulse got %b want 1", steal); end
        n_vec++; if (active_count !== 2'd2) begin n_err++; $display("FAIL steal2_count got %0d want 2", active_count); end
        tick();
        n_vec++; if (steal !== 1'b0) begin n_err++; $display("FAIL steal3_pulse got %b want 0", steal); end
    endtask
    task automatic test_release();
        keys = 4'b0101;
        tick();
        n_vec++; if (channel_ena !== 2'b11) begin n_err++; $display("FAIL rel_stolen_ena got %b want 11", channel_ena); end
        n_vec++; if (active_count !== 2'd2) begin n_err++; $display("FAIL rel_stolen_count got %0d want 2", active_count); end
        keys = 4'b0100;
        tick();
        n_vec++; if (channel_ena !== 2'b01) begin n_err++; $display("FAIL rel_ena got %b want 01", channel_ena); end
        n_vec++; if (active_count !== 2'd1) begin n_err++; $display("FAIL rel_count got %0d want 1", active_count); end
        n_vec++; if (pitches[23:12] !== 12'd424) begin n_err++; $display("FAIL rel_retain got %0d want 424", pitches[23:12]); end
    endtask
    task automatic test_cancel();
        keys = 4'b1011;
        tick();
        n_vec++; if (channel_ena !== 2'b00) begin n_err++; $display("FAIL cancel_p0_ena got %b want 00", channel_ena); end
        keys = 4'b0011;
        tick();
        n_vec++; if (channel_ena !== 2'b01) begin n_err++; $display("FAIL cancel_p1_ena got %b want 01", channel_ena); end
        n_vec++; if (pitches[11:0] !== 12'd424) begin n_err++; $display("FAIL cancel_p1_pitch got %0d want 424", pitches[11:0]); end
        tick();
        n_vec++; if (channel_ena !== 2'b11) begin n_err++; $display("FAIL cancel_p2_ena got %b want 11", channel_ena); end
        tick();
        n_vec++; if (pitches !== {12'd212, 12'd424}) begin n_err++; $display("FAIL cancel_final_pitches got %0h want %0h", pitches, {12'd212, 12'd424}); end
        n_vec++; if (active_count !== 2'd2) begin n_err++; $display("FAIL cancel_final_count got %0d want 2", active_count); end
    endtask
    task automatic test_mode();
        demo_channel_ena = 2'b10;
        demo_pitches = {12'd300, 12'd77};
        demo_waveforms = 4'b1101;
        demo_req = 1;
        tick();
        n_vec++; if (channel_ena !== 2'b10) begin n_err++; $display("FAIL demo_ena_bus got %b want 10", channel_ena); end
        n_vec++; if (pitches[23:12] !== 12'd300) begin n_err++; $display("FAIL demo_pitch got %0d want 300", pitches[23:12]); end
        n_vec++; if (waveforms !== 4'b1101) begin n_err++; $display("FAIL demo_wave got %b want 1101", waveforms); end
        n_vec++; if (demo_ena !== 1'b1) begin n_err++; $display("FAIL demo_flag got %b want 1", demo_ena); end
        n_vec++; if (active_count !== 2'd0) begin n_err++; $display("FAIL demo_count got %0d want 0", active_count); end
        keys = 4'b0111;
        tick();
        n_vec++; if (channel_ena !== 2'b10) begin n_err++; $display("FAIL demo_keys_ignored got %b want 10", channel_ena); end
        play_req = 1;
        tick();
        n_vec++; if (channel_ena !== 2'b00) begin n_err++; $display("FAIL play_ena got %b want 00", channel_ena); end
        n_vec++; if (active_count !== 2'd0) begin n_err++; $display("FAIL play_count got %0d want 0", active_count); end
        n_vec++; if (demo_ena !== 1'b0) begin n_err++; $display("FAIL play_flag got %b want 0", demo_ena); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (channel_ena !== 2'b00) begin n_err++; $display("FAIL no_retrigger[%0d] got %b want 00", i, channel_ena); end
        end
        keys = 4'b0110;
        tick();
        keys = 4'b0111;
        tick();
        n_vec++; if (channel_ena !== 2'b01) begin n_err++; $display("FAIL repress_ena got %b want 01", channel_ena); end
        n_vec++; if (pitches[11:0] !== 12'd424) begin n_err++; $display("FAIL repress_pitch got %0d want 424", pitches[11:0]); end
        demo_req = 1;
        play_req = 1;
        tick();
        n_vec++; if (demo_ena !== 1'b1) begin n_err++; $display("FAIL both_req_flag got %b want 1", demo_ena); end
        n_vec++; if (channel_ena !== 2'b10) begin n_err++; $display("FAIL both_req_ena got %b want 10", channel_ena); end
    endtask
    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 4) == 0) keys[i] = ~keys[i];
            waveform_sel = 2'($urandom);
            demo_req = ($urandom_range(0, 49) == 0);
            play_req = (c == 0) || ($urandom_range(0, 29) == 0);
            demo_channel_ena = 2'($urandom);
            demo_waveforms = 4'($urandom);
            demo_pitches = 24'($urandom);
            tick();
            n_vec++; if (channel_ena !== e_ena) begin n_err++; $display("FAIL rnd_ena cyc %0d got %b want %b", c, channel_ena, e_ena); end
            n_vec++; if (pitches !== e_pit) begin n_err++; $display("FAIL rnd_pitches cyc %0d got %0h want %0h", c, pitches, e_pit); end
            n_vec++; if (waveforms !== e_wav) begin n_err++; $display("FAIL rnd_waves cyc %0d got %b want %b", c, waveforms, e_wav); end
            n_vec++; if (demo_ena !== e_demo) begin n_err++; $display("FAIL rnd_demo cyc %0d got %b want %b", c, demo_ena, e_demo); end
            n_vec++; if (active_count !== e_cnt) begin n_err++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, active_count, e_cnt); end
            n_vec++; if (steal !== e_steal) begin n_err++; $display("FAIL rnd_steal cyc %0d got %b want %b", c, steal, e_steal); end
        end
    endtask
    initial begin
        test_reset();
        test_alloc();
        test_steal();
        test_release();
        test_cancel();
        test_mode();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
